// File: rtl/st7735_pkg.sv
// Shared ST7735 definitions: opcodes, command FSM states and window checks.
package st7735_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR,
        ST_SKIP
    } cmd_state_t;

    // A window edge pair is legal when start <= end and end lies inside the panel.
    function automatic logic window_ok(input logic [15:0] s, input logic [15:0] e,
                                       input int unsigned limit);
        return (s <= e) && (32'(e) < limit);
    endfunction

endpackage

// File: rtl/st7735_receiver_if.sv
// SPI link inputs and decoded pixel/command/status outputs of the receiver.
interface st7735_receiver_if;
    logic        LCD_CLK;
    logic        CS;
    logic        MOSI;
    logic        DC;
    logic        PIXEL_VALID;
    logic [7:0]  PIXEL_X;
    logic [7:0]  PIXEL_Y;
    logic [15:0] PIXEL_DATA;
    logic        CMD_VALID;
    logic [7:0]  CMD_BYTE;
    logic        SLEEP_OUT;
    logic        DISPLAY_ON;
    logic        FRAME_DONE;
    logic        ERROR;

    modport slave (
        input  LCD_CLK, CS, MOSI, DC,
        output PIXEL_VALID, PIXEL_X, PIXEL_Y, PIXEL_DATA, CMD_VALID, CMD_BYTE,
               SLEEP_OUT, DISPLAY_ON, FRAME_DONE, ERROR
    );

    modport master (
        output LCD_CLK, CS, MOSI, DC,
        input  PIXEL_VALID, PIXEL_X, PIXEL_Y, PIXEL_DATA, CMD_VALID, CMD_BYTE,
               SLEEP_OUT, DISPLAY_ON, FRAME_DONE, ERROR
    );
endinterface

// File: rtl/st7735_receiver_spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronizes the asynchronous link, detects LCD_CLK
// rising edges and assembles MSB-first bytes with the DC bit taken at bit 0.
module spi_byte_rx (
    input  logic       SYSTEM_CLK,
    input  logic       RESET,
    input  logic       lcd_clk,
    input  logic       cs,
    input  logic       mosi,
    input  logic       dc,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc
);

    logic [1:0] clk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic [1:0] dc_sync;
    logic       clk_prev;
    logic [6:0] shift;
    logic [2:0] bit_cnt;
    logic       clk_rise;

    // Two-flop synchronizers; CS resets to deselected so no bit is taken at release.
    always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
        if (RESET) begin
            clk_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            dc_sync   <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], lcd_clk};
            cs_sync   <= {cs_sync[0], cs};
            mosi_sync <= {mosi_sync[0], mosi};
            dc_sync   <= {dc_sync[0], dc};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_rise = clk_sync[1] & ~clk_prev;

    // Shift in one bit per LCD_CLK rise while selected; CS high drops a partial byte.
    always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
        if (RESET) begin
            shift      <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_sync[1]) begin
                bit_cnt <= '0;
            end else if (clk_rise) begin
                shift   <= {shift[5:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift, mosi_sync[1]};
                    byte_dc    <= dc_sync[1];
                end
            end
        end
    end

endmodule

// File: rtl/st7735_receiver.sv
// ST7735 display-side receiver: decodes the command stream into window setup,
// status flags and addressed RGB565 pixel writes.
module st7735_receiver
    import st7735_pkg::*;
#(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic               SYSTEM_CLK,
    input  logic               RESET,
    st7735_receiver_if.slave   bus
);

    localparam logic [7:0] XE_DEF = 8'(WIDTH - 1);
    localparam logic [7:0] YE_DEF = 8'(HEIGHT - 1);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_dc;

    spi_byte_rx u_rx (
        .SYSTEM_CLK (SYSTEM_CLK),
        .RESET      (RESET),
        .lcd_clk    (bus.LCD_CLK),
        .cs         (bus.CS),
        .mosi       (bus.MOSI),
        .dc         (bus.DC),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .byte_dc    (rx_dc)
    );

    cmd_state_t  state_q, state_n;
    logic [7:0]  xs_q, xe_q, ys_q, ye_q, xs_n, xe_n, ys_n, ye_n;
    logic [7:0]  cx_q, cy_q, cx_n, cy_n;
    logic [23:0] arg_q, arg_n;
    logic [2:0]  arg_cnt_q, arg_cnt_n;
    logic        phase_q, phase_n;
    logic [7:0]  hi_q, hi_n;
    logic        sleep_q, sleep_n, disp_q, disp_n, err_q, err_n;
    logic        pix_valid_q, pix_valid_n, frame_q, frame_n, cmd_valid_q, cmd_valid_n;
    logic [7:0]  px_q, px_n, py_q, py_n, cmd_byte_q, cmd_byte_n;
    logic [15:0] pdata_q, pdata_n;
    logic [15:0] win_s, win_e;

    // Register all FSM, window, cursor and output state.
    always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            xs_q        <= '0;
            xe_q        <= XE_DEF;
            ys_q        <= '0;
            ye_q        <= YE_DEF;
            cx_q        <= '0;
            cy_q        <= '0;
            arg_q       <= '0;
            arg_cnt_q   <= '0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            sleep_q     <= 1'b0;
            disp_q      <= 1'b0;
            err_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            frame_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
            pdata_q     <= '0;
            cmd_byte_q  <= '0;
        end else begin
            state_q     <= state_n;
            xs_q        <= xs_n;
            xe_q        <= xe_n;
            ys_q        <= ys_n;
            ye_q        <= ye_n;
            cx_q        <= cx_n;
            cy_q        <= cy_n;
            arg_q       <= arg_n;
            arg_cnt_q   <= arg_cnt_n;
            phase_q     <= phase_n;
            hi_q        <= hi_n;
            sleep_q     <= sleep_n;
            disp_q      <= disp_n;
            err_q       <= err_n;
            pix_valid_q <= pix_valid_n;
            frame_q     <= frame_n;
            cmd_valid_q <= cmd_valid_n;
            px_q        <= px_n;
            py_q        <= py_n;
            pdata_q     <= pdata_n;
            cmd_byte_q  <= cmd_byte_n;
        end
    end

    // Command dispatch, window argument collection and RAMWR pixel/cursor stepping.
    always_comb begin
        state_n     = state_q;
        xs_n        = xs_q;
        xe_n        = xe_q;
        ys_n        = ys_q;
        ye_n        = ye_q;
        cx_n        = cx_q;
        cy_n        = cy_q;
        arg_n       = arg_q;
        arg_cnt_n   = arg_cnt_q;
        phase_n     = phase_q;
        hi_n        = hi_q;
        sleep_n     = sleep_q;
        disp_n      = disp_q;
        err_n       = err_q;
        pix_valid_n = 1'b0;
        frame_n     = 1'b0;
        cmd_valid_n = 1'b0;
        px_n        = px_q;
        py_n        = py_q;
        pdata_n     = pdata_q;
        cmd_byte_n  = cmd_byte_q;
        win_s       = {arg_q[23:8]};
        win_e       = {arg_q[7:0], rx_data};

        if (rx_valid) begin
            if (!rx_dc) begin
                cmd_valid_n = 1'b1;
                cmd_byte_n  = rx_data;
                arg_cnt_n   = '0;
                phase_n     = 1'b0;
                case (rx_data)
                    CMD_SWRESET: begin
                        xs_n    = '0;
                        xe_n    = XE_DEF;
                        ys_n    = '0;
                        ye_n    = YE_DEF;
                        cx_n    = '0;
                        cy_n    = '0;
                        sleep_n = 1'b0;
                        disp_n  = 1'b0;
                        err_n   = 1'b0;
                        state_n = ST_IDLE;
                    end
                    CMD_SLPIN:   begin sleep_n = 1'b0; state_n = ST_IDLE; end
                    CMD_SLPOUT:  begin sleep_n = 1'b1; state_n = ST_IDLE; end
                    CMD_DISPOFF: begin disp_n  = 1'b0; state_n = ST_IDLE; end
                    CMD_DISPON:  begin disp_n  = 1'b1; state_n = ST_IDLE; end
                    CMD_CASET:   state_n = ST_CASET;
                    CMD_RASET:   state_n = ST_RASET;
                    CMD_RAMWR: begin
                        state_n = ST_RAMWR;
                        cx_n    = xs_q;
                        cy_n    = ys_q;
                    end
                    default:     state_n = ST_SKIP;
                endcase
            end else begin
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        if (arg_cnt_q < 3'd3) begin
                            arg_n     = {arg_q[15:0], rx_data};
                            arg_cnt_n = arg_cnt_q + 3'd1;
                        end else if (arg_cnt_q == 3'd3) begin
                            arg_cnt_n = 3'd4;
                            if (state_q == ST_CASET) begin
                                if (window_ok(win_s, win_e, WIDTH)) begin
                                    xs_n = win_s[7:0];
                                    xe_n = win_e[7:0];
                                end else begin
                                    err_n = 1'b1;
                                end
                            end else begin
                                if (window_ok(win_s, win_e, HEIGHT)) begin
                                    ys_n = win_s[7:0];
                                    ye_n = win_e[7:0];
                                end else begin
                                    err_n = 1'b1;
                                end
                            end
                        end
                    end
                    ST_RAMWR: begin
                        if (!phase_q) begin
                            hi_n    = rx_data;
                            phase_n = 1'b1;
                        end else begin
                            phase_n     = 1'b0;
                            pix_valid_n = 1'b1;
                            px_n        = cx_q;
                            py_n        = cy_q;
                            pdata_n     = {hi_q, rx_data};
                            if (cx_q == xe_q) begin
                                cx_n = xs_q;
                                if (cy_q == ye_q) begin
                                    cy_n    = ys_q;
                                    frame_n = 1'b1;
                                end else begin
                                    cy_n = cy_q + 8'd1;
                                end
                            end else begin
                                cx_n = cx_q + 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.PIXEL_VALID = pix_valid_q;
    assign bus.PIXEL_X     = px_q;
    assign bus.PIXEL_Y     = py_q;
    assign bus.PIXEL_DATA  = pdata_q;
    assign bus.CMD_VALID   = cmd_valid_q;
    assign bus.CMD_BYTE    = cmd_byte_q;
    assign bus.SLEEP_OUT   = sleep_q;
    assign bus.DISPLAY_ON  = disp_q;
    assign bus.FRAME_DONE  = frame_q;
    assign bus.ERROR       = err_q;

endmodule

// File: tb/tb_st7735_receiver.sv
// Directed bench for st7735_receiver: drives the SPI link and checks decoded strobes and flags.
module tb_st7735_receiver;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] d;
        logic        f;
    } pix_t;

    logic SYSTEM_CLK;
    logic RESET;
    int   checks;
    int   failures;
    int   frame_cnt;
    pix_t pix_q[$];
    logic [7:0] cmd_q[$];

    st7735_receiver_if bus ();

    st7735_receiver #(.WIDTH(160), .HEIGHT(120)) dut (
        .SYSTEM_CLK (SYSTEM_CLK),
        .RESET      (RESET),
        .bus        (bus)
    );

    initial SYSTEM_CLK = 1'b0;
    always #5 SYSTEM_CLK = ~SYSTEM_CLK;

    // Record every strobe on the falling edge, away from the active edge.
    always @(negedge SYSTEM_CLK) begin
        if (bus.PIXEL_VALID)
            pix_q.push_back('{x: bus.PIXEL_X, y: bus.PIXEL_Y, d: bus.PIXEL_DATA, f: bus.FRAME_DONE});
        if (bus.CMD_VALID)
            cmd_q.push_back(bus.CMD_BYTE);
        if (bus.FRAME_DONE)
            frame_cnt++;
    end

    task automatic spi_bits(input logic dc, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bus.MOSI = d[7-i];
            bus.DC   = dc;
            #40 bus.LCD_CLK = 1'b1;
            #40 bus.LCD_CLK = 1'b0;
        end
    endtask

    task automatic cmd(input logic [7:0] d);
        spi_bits(1'b0, d, 8);
    endtask

    task automatic dat(input logic [7:0] d);
        spi_bits(1'b1, d, 8);
    endtask

    task automatic settle();
        repeat (10) @(posedge SYSTEM_CLK);
        #1;
    endtask

    task automatic clear_logs();
        pix_q.delete();
        cmd_q.delete();
        frame_cnt = 0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge SYSTEM_CLK);
        #1;
        checks++;
        if ({bus.PIXEL_VALID, bus.PIXEL_X, bus.PIXEL_Y, bus.PIXEL_DATA, bus.CMD_VALID, bus.CMD_BYTE,
             bus.SLEEP_OUT, bus.DISPLAY_ON, bus.FRAME_DONE, bus.ERROR} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: pv=%b x=%0d y=%0d d=%h cv=%b cb=%h so=%b on=%b fd=%b err=%b, all required 0",
                     bus.PIXEL_VALID, bus.PIXEL_X, bus.PIXEL_Y, bus.PIXEL_DATA, bus.CMD_VALID, bus.CMD_BYTE,
                     bus.SLEEP_OUT, bus.DISPLAY_ON, bus.FRAME_DONE, bus.ERROR);
        end
        RESET = 1'b0;
        #100 bus.CS = 1'b0;
        #100;
    endtask

    task automatic test_power_cmds();
        clear_logs();
        cmd(8'h11);
        cmd(8'h29);
        settle();
        checks++;
        if (cmd_q.size() !== 2) begin
            failures++;
            $display("FAIL power_cmd_count: got %0d required 2", cmd_q.size());
        end else begin
            checks++;
            if (cmd_q[0] !== 8'h11 || cmd_q[1] !== 8'h29) begin
                failures++;
                $display("FAIL power_cmd_bytes: got %h,%h required 11,29", cmd_q[0], cmd_q[1]);
            end
        end
        checks++;
        if (bus.SLEEP_OUT !== 1'b1 || bus.DISPLAY_ON !== 1'b1) begin
            failures++;
            $display("FAIL power_flags: sleep_out=%b display_on=%b required 1,1", bus.SLEEP_OUT, bus.DISPLAY_ON);
        end
        checks++;
        if (pix_q.size() !== 0) begin
            failures++;
            $display("FAIL power_no_pixel: got %0d pixels required 0", pix_q.size());
        end
    endtask

    task automatic test_window_frame();
        pix_t exp_pix[5];
        logic [15:0] colors[5];
        exp_pix[0] = '{x: 8'd100, y: 8'd50, d: 16'hF800, f: 1'b0};
        exp_pix[1] = '{x: 8'd101, y: 8'd50, d: 16'h07E0, f: 1'b0};
        exp_pix[2] = '{x: 8'd100, y: 8'd51, d: 16'h001F, f: 1'b0};
        exp_pix[3] = '{x: 8'd101, y: 8'd51, d: 16'hFFFF, f: 1'b1};
        exp_pix[4] = '{x: 8'd100, y: 8'd50, d: 16'hABCD, f: 1'b0};
        colors = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'hABCD};
        clear_logs();
        cmd(8'h2A); dat(8'd0); dat(8'd100); dat(8'd0); dat(8'd101);
        cmd(8'h2B); dat(8'd0); dat(8'd50);  dat(8'd0); dat(8'd51);
        cmd(8'h2C);
        for (int i = 0; i < 5; i++) begin
            dat(colors[i][15:8]);
            dat(colors[i][7:0]);
        end
        settle();
        checks++;
        if (pix_q.size() !== 5) begin
            failures++;
            $display("FAIL frame_pixel_count: got %0d required 5", pix_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (pix_q[i] !== exp_pix[i]) begin
                    failures++;
                    $display("FAIL frame_pixel%0d: got (%0d,%0d) %h fd=%b required (%0d,%0d) %h fd=%b", i,
                             pix_q[i].x, pix_q[i].y, pix_q[i].d, pix_q[i].f,
                             exp_pix[i].x, exp_pix[i].y, exp_pix[i].d, exp_pix[i].f);
                end
            end
        end
        checks++;
        if (frame_cnt !== 1 || bus.ERROR !== 1'b0) begin
            failures++;
            $display("FAIL frame_done_count: frames=%0d err=%b required 1,0", frame_cnt, bus.ERROR);
        end
    endtask

    task automatic test_illegal_window();
        clear_logs();
        cmd(8'h01);
        settle();
        checks++;
        if ({bus.ERROR, bus.SLEEP_OUT, bus.DISPLAY_ON, bus.CMD_BYTE} !== {3'b000, 8'h01}) begin
            failures++;
            $display("FAIL swreset_flags: err=%b so=%b on=%b cb=%h required 0,0,0,01",
                     bus.ERROR, bus.SLEEP_OUT, bus.DISPLAY_ON, bus.CMD_BYTE);
        end
        cmd(8'h2A); dat(8'd0); dat(8'd150); dat(8'd0); dat(8'd100);
        settle();
        checks++;
        if (bus.ERROR !== 1'b1) begin
            failures++;
            $display("FAIL caset_start_gt_end: err=%b required 1", bus.ERROR);
        end
        cmd(8'h2C);
        dat(8'h55); dat(8'h55);
        dat(8'h66); dat(8'h77);
        settle();
        checks++;
        if (pix_q.size() !== 2) begin
            failures++;
            $display("FAIL illegal_pixel_count: got %0d required 2", pix_q.size());
        end else begin
            checks++;
            if ({pix_q[0].x, pix_q[0].y, pix_q[0].d, pix_q[1].x, pix_q[1].y, pix_q[1].d} !==
                {8'd0, 8'd0, 16'h5555, 8'd1, 8'd0, 16'h6677}) begin
                failures++;
                $display("FAIL illegal_window_unchanged: got (%0d,%0d) %h,(%0d,%0d) %h required (0,0) 5555,(1,0) 6677",
                         pix_q[0].x, pix_q[0].y, pix_q[0].d, pix_q[1].x, pix_q[1].y, pix_q[1].d);
            end
        end
        // Boundary: last legal column accepted, row end equal to HEIGHT rejected.
        cmd(8'h01);
        cmd(8'h2A); dat(8'd0); dat(8'd0); dat(8'd0); dat(8'd159);
        settle();
        checks++;
        if (bus.ERROR !== 1'b0) begin
            failures++;
            $display("FAIL caset_end_159_legal: err=%b required 0", bus.ERROR);
        end
        cmd(8'h2B); dat(8'd0); dat(8'd0); dat(8'd0); dat(8'd120);
        settle();
        checks++;
        if (bus.ERROR !== 1'b1) begin
            failures++;
            $display("FAIL raset_end_120_illegal: err=%b required 1", bus.ERROR);
        end
    endtask

    task automatic test_cs_abort();
        cmd(8'h01);
        cmd(8'h2C);
        settle();
        clear_logs();
        spi_bits(1'b1, 8'hFF, 5);
        bus.CS = 1'b1;
        #100 bus.CS = 1'b0;
        #100;
        dat(8'h12); dat(8'h34);
        settle();
        checks++;
        if (pix_q.size() !== 1) begin
            failures++;
            $display("FAIL cs_abort_count: got %0d pixels required 1", pix_q.size());
        end else begin
            checks++;
            if ({pix_q[0].x, pix_q[0].y, pix_q[0].d} !== {8'd0, 8'd0, 16'h1234}) begin
                failures++;
                $display("FAIL cs_abort_pixel: got (%0d,%0d) %h required (0,0) 1234",
                         pix_q[0].x, pix_q[0].y, pix_q[0].d);
            end
        end
    endtask

    task automatic test_odd_byte();
        cmd(8'h28);
        settle();
        checks++;
        if (bus.DISPLAY_ON !== 1'b0) begin
            failures++;
            $display("FAIL dispoff: display_on=%b required 0", bus.DISPLAY_ON);
        end
        clear_logs();
        cmd(8'h2C);
        dat(8'hAA); dat(8'hBB); dat(8'hCC);
        cmd(8'h29);
        dat(8'hDD); dat(8'hEE);
        settle();
        checks++;
        if (pix_q.size() !== 1) begin
            failures++;
            $display("FAIL odd_byte_count: got %0d pixels required 1", pix_q.size());
        end else begin
            checks++;
            if (pix_q[0].d !== 16'hAABB) begin
                failures++;
                $display("FAIL odd_byte_data: got %h required aabb", pix_q[0].d);
            end
        end
        checks++;
        if (bus.DISPLAY_ON !== 1'b1 || bus.CMD_BYTE !== 8'h29) begin
            failures++;
            $display("FAIL odd_byte_dispon: on=%b cb=%h required 1,29", bus.DISPLAY_ON, bus.CMD_BYTE);
        end
    endtask

    task automatic test_reset_mid();
        cmd(8'h11);
        cmd(8'h2C);
        dat(8'h12);
        spi_bits(1'b1, 8'h34, 4);
        RESET = 1'b1;
        #1;
        checks++;
        if ({bus.PIXEL_VALID, bus.PIXEL_X, bus.PIXEL_Y, bus.PIXEL_DATA, bus.CMD_VALID, bus.CMD_BYTE,
             bus.SLEEP_OUT, bus.DISPLAY_ON, bus.FRAME_DONE, bus.ERROR} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: cb=%h so=%b on=%b err=%b d=%h, all required 0",
                     bus.CMD_BYTE, bus.SLEEP_OUT, bus.DISPLAY_ON, bus.ERROR, bus.PIXEL_DATA);
        end
        repeat (4) @(posedge SYSTEM_CLK);
        clear_logs();
        RESET = 1'b0;
        bus.CS = 1'b1;
        #100 bus.CS = 1'b0;
        #100;
        settle();
        checks++;
        if (pix_q.size() !== 0 || cmd_q.size() !== 0) begin
            failures++;
            $display("FAIL midreset_no_strobe: pixels=%0d cmds=%0d required 0,0", pix_q.size(), cmd_q.size());
        end
        dat(8'h11); dat(8'h22);
        settle();
        checks++;
        if (pix_q.size() !== 0) begin
            failures++;
            $display("FAIL midreset_idle_data: got %0d pixels required 0", pix_q.size());
        end
        cmd(8'h2C);
        dat(8'h56); dat(8'h78);
        settle();
        checks++;
        if (pix_q.size() !== 1) begin
            failures++;
            $display("FAIL midreset_ramwr_count: got %0d pixels required 1", pix_q.size());
        end else begin
            checks++;
            if ({pix_q[0].x, pix_q[0].y, pix_q[0].d} !== {8'd0, 8'd0, 16'h5678}) begin
                failures++;
                $display("FAIL midreset_ramwr_pixel: got (%0d,%0d) %h required (0,0) 5678",
                         pix_q[0].x, pix_q[0].y, pix_q[0].d);
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        frame_cnt   = 0;
        RESET       = 1'b1;
        bus.LCD_CLK = 1'b0;
        bus.CS      = 1'b1;
        bus.MOSI    = 1'b0;
        bus.DC      = 1'b0;
        test_reset();
        test_power_cmds();
        test_window_frame();
        test_illegal_window();
        test_cs_abort();
        test_odd_byte();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
